// File: rtl/nios2_clkgen_pkg.sv
// Shared types and constants for the nios2_clkgen clock generator.
package nios2_clkgen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_LOCKED = 2'd3
   } clkgen_state_t;

   localparam int MIN_DIV    = 2;
   localparam int CHAN_IDX_W = 3;

endpackage

// File: rtl/nios2_clkgen_chan.sv
// One output channel: phase-loadable modulo counter with registered clock and enable outputs.
module nios2_clkgen_chan
   import nios2_clkgen_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             run,
   input  logic             out_en,
   input  logic [CNT_W-1:0] div,
   input  logic [CNT_W-1:0] phase,
   output logic             outclk,
   output logic             clk_en
);

   logic [CNT_W-1:0] d_eff;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             outclk_reg, clk_en_reg;

   assign d_eff = (div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div;

   always_comb begin
      cnt_next = cnt_reg;
      if (load) begin
         cnt_next = (phase >= d_eff) ? '0 : phase;
      end else if (run) begin
         cnt_next = (cnt_reg >= d_eff - CNT_W'(1)) ? '0 : cnt_reg + CNT_W'(1);
      end
   end

   // Outputs are decoded from the next count so they line up with cnt_reg.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg    <= '0;
         outclk_reg <= 1'b0;
         clk_en_reg <= 1'b0;
      end else begin
         cnt_reg    <= cnt_next;
         outclk_reg <= out_en && (cnt_next < (d_eff >> 1));
         clk_en_reg <= out_en && (cnt_next == d_eff - CNT_W'(1));
      end
   end

   assign outclk = outclk_reg;
   assign clk_en = clk_en_reg;

endmodule

// File: rtl/nios2_clkgen.sv
// Multi-channel divided clock generator with programmable divide/phase and lock tracking.
module nios2_clkgen
   import nios2_clkgen_pkg::*;
#(
   parameter int NUM_CLOCKS  = 4,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 2,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                  refclk,
   input  logic                  rst_n,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CHAN_IDX_W-1:0] cfg_chan,
   input  logic [CNT_W-1:0]      cfg_div,
   input  logic [CNT_W-1:0]      cfg_phase,
   output logic                  cfg_err,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic [NUM_CLOCKS-1:0] clk_en,
   output logic                  locked
);

   localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

   clkgen_state_t     state_reg, state_next;
   logic [LOCK_W-1:0] lock_cnt_reg, lock_cnt_next;
   logic              locked_reg, cfg_err_reg;
   logic              cfg_fire, chan_ok, wr_valid;
   logic              chan_load, chan_run, chan_out_en;

   assign cfg_ready   = (state_reg == ST_SETTLE) || (state_reg == ST_LOCKED);
   assign cfg_fire    = cfg_valid && cfg_ready;
   assign chan_ok     = 32'(cfg_chan) < NUM_CLOCKS;
   assign wr_valid    = cfg_fire && chan_ok;
   assign chan_load   = (state_reg == ST_ALIGN);
   assign chan_run    = cfg_ready;
   assign chan_out_en = (state_next == ST_SETTLE) || (state_next == ST_LOCKED);

   always_comb begin
      state_next    = state_reg;
      lock_cnt_next = lock_cnt_reg;
      case (state_reg)
         ST_IDLE: state_next = ST_ALIGN;
         ST_ALIGN: begin
            state_next    = ST_SETTLE;
            lock_cnt_next = '0;
         end
         ST_SETTLE: begin
            if (wr_valid) begin
               state_next = ST_ALIGN;
            end else if (lock_cnt_reg == LOCK_W'(LOCK_CYCLES - 1)) begin
               state_next = ST_LOCKED;
            end else begin
               lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
            end
         end
         ST_LOCKED: begin
            if (wr_valid) state_next = ST_ALIGN;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         lock_cnt_reg <= '0;
         locked_reg   <= 1'b0;
         cfg_err_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         lock_cnt_reg <= lock_cnt_next;
         locked_reg   <= (state_next == ST_LOCKED);
         cfg_err_reg  <= cfg_fire && !chan_ok;
      end
   end

   assign locked  = locked_reg;
   assign cfg_err = cfg_err_reg;

   // Every valid write realigns all channels, so shadows only change on a hit.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CLOCKS; gi++) begin : g_chan
         logic [CNT_W-1:0] div_reg, phase_reg;
         logic             wr_hit;

         assign wr_hit = wr_valid && (cfg_chan == CHAN_IDX_W'(gi));

         always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
               div_reg   <= CNT_W'(DEFAULT_DIV);
               phase_reg <= '0;
            end else if (wr_hit) begin
               div_reg   <= cfg_div;
               phase_reg <= cfg_phase;
            end
         end

         nios2_clkgen_chan #(
            .CNT_W(CNT_W)
         ) u_chan (
            .clk    (refclk),
            .rst_n  (rst_n),
            .load   (chan_load),
            .run    (chan_run),
            .out_en (chan_out_en),
            .div    (div_reg),
            .phase  (phase_reg),
            .outclk (outclk[gi]),
            .clk_en (clk_en[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_nios2_clkgen.sv
// Directed self-checking bench for nios2_clkgen with default parameters.
module tb_nios2_clkgen;

   logic        refclk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [2:0]  cfg_chan;
   logic [15:0] cfg_div;
   logic [15:0] cfg_phase;
   logic        cfg_err;
   logic [3:0]  outclk;
   logic [3:0]  clk_en;
   logic        locked;

   int tests = 0;
   int fails = 0;

   nios2_clkgen #(
      .NUM_CLOCKS  (4),
      .CNT_W       (16),
      .DEFAULT_DIV (2),
      .LOCK_CYCLES (16)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_chan  (cfg_chan),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .cfg_err   (cfg_err),
      .outclk    (outclk),
      .clk_en    (clk_en),
      .locked    (locked)
   );

   always #5 refclk = ~refclk;

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] ch, input logic [15:0] d, input logic [15:0] p);
      cfg_chan  = ch;
      cfg_div   = d;
      cfg_phase = p;
      cfg_valid = 1'b1;
      tick(1);
      cfg_valid = 1'b0;
      $display("[TB] write chan=%0d div=%0d phase=%0d accepted at %0t", ch, d, p, $time);
   endtask

   task automatic relock_from_reset(input string pfx);
      rst_n = 1'b1;
      tick(1);
      chk({pfx, "_e1_ready"}, 32'(cfg_ready), 32'h0);
      chk({pfx, "_e1_outclk"}, 32'(outclk), 32'h0);
      tick(1);
      chk({pfx, "_e2_ready"}, 32'(cfg_ready), 32'h1);
      chk({pfx, "_e2_outclk"}, 32'(outclk), 32'hF);
      chk({pfx, "_e2_clken"}, 32'(clk_en), 32'h0);
      tick(1);
      chk({pfx, "_e3_outclk"}, 32'(outclk), 32'h0);
      chk({pfx, "_e3_clken"}, 32'(clk_en), 32'hF);
      tick(14);
      chk({pfx, "_e17_locked"}, 32'(locked), 32'h0);
      tick(1);
      chk({pfx, "_e18_locked"}, 32'(locked), 32'h1);
      chk({pfx, "_e18_outclk"}, 32'(outclk), 32'hF);
      tick(1);
      chk({pfx, "_e19_outclk"}, 32'(outclk), 32'h0);
      chk({pfx, "_e19_clken"}, 32'(clk_en), 32'hF);
   endtask

   initial begin
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_chan  = '0;
      cfg_div   = '0;
      cfg_phase = '0;

      // Reset state
      tick(3);
      chk("rst_outclk", 32'(outclk), 32'h0);
      chk("rst_clken", 32'(clk_en), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_ready", 32'(cfg_ready), 32'h0);
      chk("rst_err", 32'(cfg_err), 32'h0);

      // Default relock: locked after 18th edge, div-2 outputs in phase
      relock_from_reset("boot");

      // Invalid channel write while locked
      wr(3'd7, 16'd3, 16'd0);
      chk("bad_err", 32'(cfg_err), 32'h1);
      chk("bad_locked", 32'(locked), 32'h1);
      chk("bad_outclk", 32'(outclk), 32'hF);
      chk("bad_clken", 32'(clk_en), 32'h0);
      tick(1);
      chk("bad_err_clr", 32'(cfg_err), 32'h0);
      chk("bad_locked2", 32'(locked), 32'h1);
      chk("bad_outclk2", 32'(outclk), 32'h0);
      chk("bad_clken2", 32'(clk_en), 32'hF);

      // Chan 1 div 5 phase 0 while locked
      wr(3'd1, 16'd5, 16'd0);
      chk("d5_locked_fall", 32'(locked), 32'h0);
      chk("d5_align_ready", 32'(cfg_ready), 32'h0);
      chk("d5_align_outclk", 32'(outclk), 32'h0);
      for (int k = 0; k < 10; k++) begin
         tick(1);
         chk("d5_out1", 32'(outclk[1]), 32'((k % 5) < 2));
         chk("d5_en1", 32'(clk_en[1]), 32'((k % 5) == 4));
         chk("d5_out0", 32'(outclk[0]), 32'((k % 2) == 0));
      end
      tick(6);
      chk("d5_locked_pre", 32'(locked), 32'h0);
      tick(1);
      chk("d5_locked", 32'(locked), 32'h1);

      // Chan 2 div 4 phase 2, then chan 0 div 4 phase 0: chan 2 lags chan 0 by 2
      wr(3'd2, 16'd4, 16'd2);
      tick(1);
      wr(3'd0, 16'd4, 16'd0);
      for (int k = 0; k < 8; k++) begin
         tick(1);
         if (k == 0) chk("ph_first_outclk", 32'(outclk), 32'hB);
         chk("ph_out0", 32'(outclk[0]), 32'((k % 4) < 2));
         chk("ph_out2", 32'(outclk[2]), 32'(((k + 2) % 4) < 2));
         chk("ph_en2", 32'(clk_en[2]), 32'(((k + 2) % 4) == 3));
      end

      // Chan 3 div 4 phase 6 (loads 0); restarted 5 cycles into SETTLE by chan 1 div 0
      wr(3'd3, 16'd4, 16'd6);
      tick(5);
      chk("rs_ready", 32'(cfg_ready), 32'h1);
      chk("rs_locked", 32'(locked), 32'h0);
      wr(3'd1, 16'd0, 16'd0);
      chk("rs_align_ready", 32'(cfg_ready), 32'h0);
      for (int k = 0; k < 8; k++) begin
         tick(1);
         chk("div0_out1", 32'(outclk[1]), 32'((k % 2) == 0));
         chk("div0_en1", 32'(clk_en[1]), 32'((k % 2) == 1));
         chk("ph6_out3", 32'(outclk[3]), 32'((k % 4) < 2));
         chk("ph6_en3", 32'(clk_en[3]), 32'((k % 4) == 3));
      end
      tick(8);
      chk("rs_locked_pre", 32'(locked), 32'h0);
      tick(1);
      chk("rs_locked", 32'(locked), 32'h1);
      chk("rs_outclk", 32'(outclk), 32'hB);
      chk("rs_clken", 32'(clk_en), 32'h0);

      // Asynchronous reset mid-LOCKED
      rst_n = 1'b0;
      #2;
      chk("arst_outclk", 32'(outclk), 32'h0);
      chk("arst_clken", 32'(clk_en), 32'h0);
      chk("arst_locked", 32'(locked), 32'h0);
      chk("arst_ready", 32'(cfg_ready), 32'h0);
      tick(2);
      relock_from_reset("rerst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
